// File: rtl/gearbox_1_to_n.sv
// Packs `ratio` narrow upstream words into one wide downstream word, with valid/ready on both sides.
// Optional GEARBOX_LAST_EN adds up_last/down_last/down_keep for early termination of a packet.
module gearbox_1_to_n #(
    parameter int width = 8,
    parameter int ratio = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_vld,
    output logic                     up_rdy,
    input  logic [width-1:0]         up_data,
`ifdef GEARBOX_LAST_EN
    input  logic                     up_last,
    output logic                     down_last,
    output logic [ratio-1:0]         down_keep,
`endif
    output logic                     down_vld,
    input  logic                     down_rdy,
    output logic [ratio*width-1:0]   down_data
);

    localparam int CW = $clog2(ratio);
    localparam logic [CW-1:0] CNT_MAX = CW'(ratio - 1);

    logic [CW-1:0]              cnt;
    logic [(ratio-1)*width-1:0] acc;
    logic [(ratio-1)*width-1:0] acc_next;
    logic [ratio*width-1:0]     out_data;
    logic [ratio*width-1:0]     packed_word;
    logic                       out_full;
    logic                       complete;
    logic                       accept;
    logic                       drain;
`ifdef GEARBOX_LAST_EN
    logic [ratio-1:0]           keep_next;
    logic [ratio-1:0]           out_keep;
    logic                       out_last;
`endif

    always_comb begin
        complete = (cnt == CNT_MAX);
`ifdef GEARBOX_LAST_EN
        complete = complete | (up_vld & up_last);
`endif
        // Stall only when this beat would overwrite a word the consumer has not taken.
        up_rdy   = ~rst & (~complete | ~out_full | down_rdy);
        accept   = up_vld & up_rdy;
        drain    = out_full & down_rdy;

        acc_next    = acc;
        packed_word = '0;
        for (int i = 0; i < ratio - 1; i++) begin
            packed_word[(ratio-1-i)*width +: width] = acc[(ratio-2-i)*width +: width];
            if (i == int'(cnt)) begin
                acc_next[(ratio-2-i)*width +: width] = up_data;
            end
        end
        // Accumulator lanes past cnt are zero, so a short word gets zero lower lanes.
        for (int i = 0; i < ratio; i++) begin
            if (i == int'(cnt)) begin
                packed_word[(ratio-1-i)*width +: width] = up_data;
            end
        end
`ifdef GEARBOX_LAST_EN
        keep_next = '0;
        for (int i = 0; i < ratio; i++) begin
            keep_next[ratio-1-i] = (i <= int'(cnt));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            out_full <= 1'b0;
            out_data <= '0;
`ifdef GEARBOX_LAST_EN
            out_keep <= '0;
            out_last <= 1'b0;
`endif
        end else if (accept && complete) begin
            out_data <= packed_word;
            out_full <= 1'b1;
            cnt      <= '0;
            acc      <= '0;
`ifdef GEARBOX_LAST_EN
            out_keep <= keep_next;
            out_last <= up_last;
`endif
        end else begin
            if (accept) begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
            end
            if (drain) begin
                out_full <= 1'b0;
                out_data <= '0;
`ifdef GEARBOX_LAST_EN
                out_keep <= '0;
                out_last <= 1'b0;
`endif
            end
        end
    end

    assign down_vld  = out_full;
    assign down_data = out_data;
`ifdef GEARBOX_LAST_EN
    assign down_keep = out_keep;
    assign down_last = out_last;
`endif

endmodule
